hazard_stall_unit: RTL
======================

Name: hazard_stall_unit

Overview:
- Stall-side complement to the EX-stage forwarding logic in the 5-stage MIPS32 pipeline.
- Detects hazards that bypassing cannot resolve: load-use, ID-stage branch operand dependencies, and a pending multicycle MDU (mul/div) result.
- Drives PC/IF-ID write enables and the ID/EX bubble.
- Holds a one-entry scoreboard with a latency counter for the MDU destination register.

Parameters:
- MDU_LATENCY, 4, cycles from MDU issue in EX to result available for writeback; legal range 2..15.
- REG_W, 5, register specifier width.
- CNT_W is a localparam, not overridable: clog2(MDU_LATENCY)+1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset
- rs1_ifid  in  REG_W  source 1 of the instruction in ID
- rs2_ifid  in  REG_W  source 2 of the instruction in ID
- use_rs1_id  in  1  ID instruction reads rs1
- use_rs2_id  in  1  ID instruction reads rs2
- branch_id  in  1  ID instruction is a branch that compares operands in ID
- mdu_op_id  in  1  ID instruction is an MDU op
- rd_idex  in  REG_W  destination of the EX instruction
- writeBack_idex  in  1  EX instruction writes a register
- memread_idex  in  1  EX instruction is a load
- mdu_start_idex  in  1  EX instruction issues to the MDU this cycle
- rd_exmem  in  REG_W  destination of the MEM instruction
- memread_exmem  in  1  MEM instruction is a load
- pc_write_en  out  1  PC may update
- ifid_write_en  out  1  IF/ID register may update
- idex_bubble  out  1  zero the ID/EX control fields
- mdu_busy  out  1  scoreboard entry valid
- mdu_done  out  1  one-cycle pulse when the MDU result is ready
- mdu_rd  out  REG_W  destination register held by the scoreboard

Behaviour:
- Reset: rst, synchronous, active-high.
  - While rst is high and on the following edge: state=RUN, cnt=0, mdu_rd=0, mdu_busy=0, mdu_done=0.
  - While rst is high, combinational outputs are forced to pc_write_en=1, ifid_write_en=1, idex_bubble=0.
- Definition: match(r) = (r!=0) && ((use_rs1_id && r==rs1_ifid) || (use_rs2_id && r==rs2_ifid)).
- Load-use: lu = memread_idex && match(rd_idex).
- Branch: br = branch_id && ((writeBack_idex && match(rd_idex)) || (memread_exmem && match(rd_exmem))).
- MDU: md = mdu_busy && (match(mdu_rd) || mdu_op_id).
- Stall: stall = lu|br|md, combinational, same cycle.
  - pc_write_en = !stall; ifid_write_en = !stall; idex_bubble = stall.
  - Any stall source asserts all three outputs; there is no priority among sources.
- FSM with two states, RUN and MDU_WAIT:
  - RUN: on mdu_start_idex, load cnt=MDU_LATENCY-1, latch mdu_rd<=rd_idex, go to MDU_WAIT.
  - MDU_WAIT: decrement cnt each cycle.
    - When cnt==1: next cnt=0, assert mdu_done for that next cycle, return to RUN.
    - mdu_busy = (state==MDU_WAIT).
- Issue spacing: the first result is usable MDU_LATENCY cycles after mdu_start_idex.
  - mdu_done and the clear of mdu_busy coincide in the same cycle.
  - A dependent instruction in ID is released in that cycle; operands come via normal MEM/WB forwarding.
- mdu_start_idex while already in MDU_WAIT (a protocol violation, prevented by md) restarts the counter and overwrites mdu_rd; no error flag.
- mdu_start_idex in the same cycle as mdu_done: accepted; stays in MDU_WAIT with a reload.
- A scoreboard entry with rd_idex==0 is still tracked for MDU serialisation (mdu_op_id) but never matches operands.
- rst asserted in MDU_WAIT: the entry is dropped immediately; no mdu_done.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined: adds outputs stall_cycles (32-bit, +1 every cycle stall=1) and lu_count (16-bit, +1 per cycle with lu=1).
  - Both saturate at all-ones and clear on rst.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package hazard_pkg: REG_W, the FSM state encoding (RUN=0, MDU_WAIT=1), and the zero-register constant.
- One sub-module: mdu_scoreboard, holding the FSM, cnt, mdu_rd, mdu_busy, and mdu_done.
- The top level holds the combinational lu/br/md logic and the optional stats counters.

Test Plan:
- lw to $8 in EX, add reads $8 (use_rs1) in ID -> stall=1 exactly one cycle, idex_bubble=1; next cycle memread_idex=0 and stall=0.
- lw to $0 in EX, ID reads $0 -> no stall.
- beq in ID reading $5, EX add writes $5 -> one stall cycle; then lw $5 in MEM reading into the branch -> second stall cycle.
- mdu_start_idex with rd=$9, MDU_LATENCY=4, ID reads $9 -> stall for cycles 1-3 after issue; mdu_done=1 and stall=0 in cycle 4.
- Second MDU op in ID while busy -> stalled until mdu_done.
- rst asserted in the second cycle of MDU_WAIT -> mdu_busy=0 next cycle, mdu_done never asserts, pc_write_en=1.
- With HAZARD_STATS_EN defined: run the load-use and MDU scenarios back-to-back -> stall_cycles=4, lu_count=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard stall unit: register specifier width,
// MDU scoreboard state encoding and the hard-wired zero register.
package hazard_pkg;

    localparam int unsigned REG_W = 5;

    // Register $0 reads as zero and never creates a dependency.
    localparam int unsigned ZERO_REG = 0;

    typedef enum logic {
        StRun     = 1'b0,
        StMduWait = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_scoreboard.sv
// One-entry scoreboard for the multicycle MDU: tracks the destination register
// of the in-flight mul/div and counts down to the cycle its result is usable.
module mdu_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned MDU_LATENCY = 4,
    parameter int unsigned REG_W       = hazard_pkg::REG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mdu_start,
    input  logic [REG_W-1:0] rd_in,
    output logic             mdu_busy,
    output logic             mdu_done,
    output logic [REG_W-1:0] mdu_rd
);

    localparam int unsigned CNT_W = $clog2(MDU_LATENCY) + 1;
    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(MDU_LATENCY - 1);

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [REG_W-1:0] rd_q;
    logic             done_q;

    // Scoreboard FSM: a new issue always reloads, even over a pending entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
            rd_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (mdu_start) begin
                state_q <= StMduWait;
                cnt_q   <= CntLoad;
                rd_q    <= rd_in;
            end else if (state_q == StMduWait) begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_q   <= '0;
                    done_q  <= 1'b1;
                    state_q <= StRun;
                end else begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
        end
    end

    // Reset drops the entry in the same cycle it is asserted.
    always_comb begin
        mdu_busy = (state_q == StMduWait) && !rst;
        mdu_done = done_q && !rst;
        mdu_rd   = rd_q;
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall-side hazard detection for the 5-stage pipeline: load-use, ID-stage
// branch operand dependencies and pending MDU results.
// Optional statistics counters are enabled with `define HAZARD_STATS_EN.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int unsigned MDU_LATENCY = 4,
    parameter int unsigned REG_W       = hazard_pkg::REG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs1_ifid,
    input  logic [REG_W-1:0] rs2_ifid,
    input  logic             use_rs1_id,
    input  logic             use_rs2_id,
    input  logic             branch_id,
    input  logic             mdu_op_id,
    input  logic [REG_W-1:0] rd_idex,
    input  logic             writeBack_idex,
    input  logic             memread_idex,
    input  logic             mdu_start_idex,
    input  logic [REG_W-1:0] rd_exmem,
    input  logic             memread_exmem,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             idex_bubble,
    output logic             mdu_busy,
    output logic             mdu_done,
    output logic [REG_W-1:0] mdu_rd
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [15:0]      lu_count
`endif
);

    logic lu;
    logic br;
    logic md;
    logic stall;

    // True when r is a live, nonzero source of the instruction in ID.
    function automatic logic reg_match(input logic [REG_W-1:0] r,
                                       input logic [REG_W-1:0] rs1,
                                       input logic [REG_W-1:0] rs2,
                                       input logic             use1,
                                       input logic             use2);
        return (r != REG_W'(ZERO_REG)) && ((use1 && r == rs1) || (use2 && r == rs2));
    endfunction

    mdu_scoreboard #(
        .MDU_LATENCY (MDU_LATENCY),
        .REG_W       (REG_W)
    ) u_mdu_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .mdu_start (mdu_start_idex),
        .rd_in     (rd_idex),
        .mdu_busy  (mdu_busy),
        .mdu_done  (mdu_done),
        .mdu_rd    (mdu_rd)
    );

    // Hazard sources are unprioritised; any of them freezes IF/ID and bubbles EX.
    always_comb begin
        lu = memread_idex &&
             reg_match(rd_idex, rs1_ifid, rs2_ifid, use_rs1_id, use_rs2_id);
        br = branch_id &&
             ((writeBack_idex &&
               reg_match(rd_idex, rs1_ifid, rs2_ifid, use_rs1_id, use_rs2_id)) ||
              (memread_exmem &&
               reg_match(rd_exmem, rs1_ifid, rs2_ifid, use_rs1_id, use_rs2_id)));
        md = mdu_busy &&
             (reg_match(mdu_rd, rs1_ifid, rs2_ifid, use_rs1_id, use_rs2_id) || mdu_op_id);
        stall         = (lu || br || md) && !rst;
        pc_write_en   = !stall;
        ifid_write_en = !stall;
        idex_bubble   = stall;
    end

`ifdef HAZARD_STATS_EN
    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            lu_count     <= '0;
        end else begin
            if (stall && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (lu && lu_count != '1) begin
                lu_count <= lu_count + 16'd1;
            end
        end
    end
`endif

endmodule
